// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// the instruction/data width relation check used at elaboration.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_FETCH = 2'd2
  } arb_state_e;

  // An instruction is exactly one half of a memory word.
  function automatic bit inst_width_ok(int inst_w, int data_w);
    return (2 * inst_w == data_w);
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Counts consecutive data grants made while fetch was also waiting, and
// forces the next grant to fetch once the streak reaches MAX_DATA_STREAK.
module arb_streak_counter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_data,
  input  logic grant_fetch,
  input  logic contended,
  output logic force_fetch
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_max_streak
    $error("MAX_DATA_STREAK must be in 1..15");
  end

  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (grant_fetch) begin
      streak_d = '0;
    end else if (grant_data && contended && (streak_q < MaxStreak)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_fetch = contended && (streak_q == MaxStreak);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the MEM stage.
// Define ARB_FAIRNESS_EN to bound how long fetch can be starved by data.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int INST_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INST_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy
);

  if (!inst_width_ok(INST_W, DATA_W)) begin : g_bad_inst_w
    $error("INST_W must equal DATA_W/2");
  end

  arb_state_e        state_q, state_d;
  logic              grant_data, grant_fetch;
  logic              force_fetch;
  logic              m_req_q, busy_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              half_q;
  logic              if_valid_q, d_valid_q;
  logic [INST_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Fetch addresses are word-aligned; only bit 2 (half select) and up matter.
  logic unused_if_addr_bits;
  assign unused_if_addr_bits = ^if_addr[1:0];

`ifdef ARB_FAIRNESS_EN
  arb_streak_counter #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk        (clk),
    .reset      (reset),
    .grant_data (grant_data),
    .grant_fetch(grant_fetch),
    .contended  (if_req),
    .force_fetch(force_fetch)
  );
`else
  localparam int unused_max_streak = MAX_DATA_STREAK;
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (d_req && !force_fetch) begin
          grant_data = 1'b1;
          state_d    = ARB_DATA;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_d     = ARB_FETCH;
        end
      end
      ARB_DATA, ARB_FETCH: begin
        if (m_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      m_req_q    <= 1'b0;
      busy_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      half_q     <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= (state_d != ARB_IDLE);
      busy_q     <= (state_d != ARB_IDLE);
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (grant_data) begin
        m_we_q    <= d_we;
        m_addr_q  <= d_addr;
        m_wdata_q <= d_wdata;
      end
      if (grant_fetch) begin
        m_we_q    <= 1'b0;
        m_addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
        half_q    <= if_addr[2];
        m_wdata_q <= '0;
      end
      // Stores complete with a valid pulse but keep the last load data.
      if (state_q == ARB_DATA && m_ready) begin
        d_valid_q <= 1'b1;
        if (!m_we_q) begin
          d_rdata_q <= m_rdata;
        end
      end
      if (state_q == ARB_FETCH && m_ready) begin
        if_valid_q <= 1'b1;
        if_rdata_q <= half_q ? m_rdata[DATA_W-1:INST_W] : m_rdata[INST_W-1:0];
      end
    end
  end

  assign m_req    = m_req_q;
  assign busy     = busy_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req && !if_valid_q;
  assign d_stall  = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural wait-state memory.
// Fairness expectations follow ARB_FAIRNESS_EN when it is defined for the build.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural memory: answers wait_cfg cycles after m_req is first seen.
  logic [63:0] mem [logic [63:0]];
  int          wait_cfg;
  int          wcnt;
  bit          in_txn;
  logic [63:0] cap_addr, cap_wdata;
  logic        cap_we;
  bit          grant_q[$];

  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    wcnt    = 0;
    in_txn  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        m_ready = 1'b0;
        wcnt    = 0;
        in_txn  = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0;
      end else if (m_req) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          cap_addr  = m_addr;
          cap_we    = m_we;
          cap_wdata = m_wdata;
          grant_q.push_back(m_addr == 64'h100);
        end
        if (wcnt == wait_cfg) begin
          m_ready = 1'b1;
          in_txn  = 1'b0;
          wcnt    = 0;
          m_rdata = mem.exists(m_addr) ? mem[m_addr] : 64'h0;
          if (m_we) mem[m_addr] = m_wdata;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic fetch_txn(input logic [63:0] addr, output logic [31:0] inst,
                           output int lat, output logic stall_v);
    if_addr = addr;
    if_req  = 1'b1;
    lat     = 0;
    do begin
      step();
      lat++;
    end while (!if_valid && lat < 40);
    if (!if_valid) chk("if_timeout", 64'd0, 64'd1);
    inst    = if_rdata;
    stall_v = if_stall;
    if_req  = 1'b0;
    $display("fetch addr=0x%0h inst=0x%08h lat=%0d", addr, inst, lat);
  endtask

  task automatic data_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output int lat);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    lat     = 0;
    do begin
      step();
      lat++;
    end while (!d_valid && lat < 40);
    if (!d_valid) chk("d_timeout", 64'd0, 64'd1);
    rdata = d_rdata;
    d_req = 1'b0;
    $display("%s addr=0x%0h wdata=0x%0h rdata=0x%0h lat=%0d",
             we ? "store" : "load ", addr, wdata, rdata, lat);
  endtask

  initial begin
    logic [31:0] inst;
    logic [63:0] rd, a0, w0;
    logic        e0, stall_v;
    int          lat, cyc, unstable, pulses;
    bit          seen;

    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    wait_cfg = 0;
    mem[64'h100] = 64'hDEADBEEF_00000013;
    mem[64'h108] = 64'hCAFEF00D_00500093;
    mem[64'h080] = 64'hA5A5A5A5_5A5A5A5A;

    repeat (2) step();
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    step();

    // Fetch only, upper and lower halves
    fetch_txn(64'h104, inst, lat, stall_v);
    chk("fetch_hi_inst", inst, 64'hDEADBEEF);
    chk("fetch_hi_lat", lat, 2);
    chk("fetch_hi_stall", stall_v, 0);
    chk("fetch_hi_maddr", cap_addr, 64'h100);
    chk("fetch_hi_mwe", cap_we, 0);
    step();
    chk("fetch_pulse_end", if_valid, 0);
    chk("fetch_idle_busy", busy, 0);
    fetch_txn(64'h108, inst, lat, stall_v);
    chk("fetch_lo_inst", inst, 64'h00500093);
    chk("fetch_lo_maddr", cap_addr, 64'h108);

    // Load, store (d_rdata must hold), load back
    data_txn(1'b0, 64'h80, 64'h0, rd, lat);
    chk("load80_rdata", rd, 64'hA5A5A5A5_5A5A5A5A);
    chk("load80_lat", lat, 2);
    data_txn(1'b1, 64'h40, 64'h1122334455667788, rd, lat);
    chk("store_mwe", cap_we, 1);
    chk("store_maddr", cap_addr, 64'h40);
    chk("store_mwdata", cap_wdata, 64'h1122334455667788);
    chk("store_rdata_hold", rd, 64'hA5A5A5A5_5A5A5A5A);
    data_txn(1'b0, 64'h40, 64'h0, rd, lat);
    chk("load40_mwe", cap_we, 0);
    chk("load40_rdata", rd, 64'h1122334455667788);

    // Collision: data first, fetch after an IDLE cycle
    if_addr = 64'h104; d_addr = 64'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    step();
    chk("col_m_req", m_req, 1);
    chk("col_first_addr", m_addr, 64'h40);
    chk("col_if_stall1", if_stall, 1);
    chk("col_d_stall1", d_stall, 1);
    step();
    chk("col_d_valid", d_valid, 1);
    chk("col_d_stall2", d_stall, 0);
    chk("col_if_stall2", if_stall, 1);
    d_req = 1'b0;
    step();
    chk("col_second_addr", m_addr, 64'h100);
    chk("col_second_req", m_req, 1);
    chk("col_if_stall3", if_stall, 1);
    step();
    chk("col_if_valid", if_valid, 1);
    chk("col_if_rdata", if_rdata, 64'hDEADBEEF);
    if_req = 1'b0;
    $display("collision data-then-fetch done");
    step();

    // Fairness: both requesters held continuously for ten grants
    grant_q.delete();
    if_addr = 64'h104; d_addr = 64'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    cyc = 0;
    while (grant_q.size() < 10 && cyc < 200) begin
      step();
      cyc++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("fair_grant_count_reached", grant_q.size() >= 10, 1);
    for (int i = 0; i < 10; i++) begin
      bit exp_f;
`ifdef ARB_FAIRNESS_EN
      exp_f = (i % 5 == 4);
`else
      exp_f = 1'b0;
`endif
      chk($sformatf("fair_grant%0d_is_fetch", i), (i < grant_q.size()) ? grant_q[i] : 1'bx, exp_f);
      $display("grant %0d: %s", i, (i < grant_q.size() && grant_q[i]) ? "F" : "D");
    end
    cyc = 0;
    while ((busy || m_ready) && cyc < 40) begin
      step();
      cyc++;
    end
    chk("fair_drain_idle", busy, 0);
    step();

    // Wait states: five extra cycles, request must stay stable
    wait_cfg = 5;
    d_we = 1'b1; d_addr = 64'h48; d_wdata = 64'h0F0E0D0C0B0A0908; d_req = 1'b1;
    seen = 1'b0; unstable = 0; pulses = 0; lat = 0;
    a0 = '0; w0 = '0; e0 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (m_req) begin
        if (!seen) begin
          a0 = m_addr; w0 = m_wdata; e0 = m_we; seen = 1'b1;
        end else if (m_addr !== a0 || m_wdata !== w0 || m_we !== e0) begin
          unstable++;
        end
      end
      if (d_valid) begin
        pulses++;
        if (lat == 0) lat = c;
        d_req = 1'b0;
      end
    end
    $display("wait-state store addr=0x%0h lat=%0d pulses=%0d", a0, lat, pulses);
    chk("wait_stable", unstable, 0);
    chk("wait_pulses", pulses, 1);
    chk("wait_lat", lat, 7);
    chk("wait_maddr", a0, 64'h48);
    chk("wait_mwdata", w0, 64'h0F0E0D0C0B0A0908);
    chk("wait_mwe", e0, 1);

    // Reset in the middle of a data access
    d_we = 1'b0; d_addr = 64'h40; d_req = 1'b1;
    step();
    step();
    chk("rmid_m_req_before", m_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmid_m_req", m_req, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_m_addr", m_addr, 0);
    chk("rmid_m_we", m_we, 0);
    chk("rmid_d_rdata", d_rdata, 0);
    chk("rmid_if_rdata", if_rdata, 0);
    chk("rmid_d_valid", d_valid, 0);
    d_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (d_valid) pulses++;
    end
    chk("rmid_no_valid", pulses, 0);
    $display("reset mid-access: abandoned, %0d stray valid pulses", pulses);
    wait_cfg = 0;
    data_txn(1'b0, 64'h40, 64'h0, rd, lat);
    chk("rpost_rdata", rd, 64'h1122334455667788);
    chk("rpost_lat", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
